cnn_conv_mac_seq: RTL

- Sequencer for conv2 dot products. Shares one external signed 9x14 multiplier.
- Pulls weight/pixel tap pairs from two valid/ready streams and drives the multiplier operands from registers.
- Registers the 23-bit product and accumulates it, with saturation, onto a bias.
- Emits one result per command through a valid/ready output; command control uses ap_start/ap_ready/ap_idle.

---
 rtl/cnn_conv_mac_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cnn_conv_mac_seq.sv
// Conv2 dot-product sequencer: feeds a shared external signed multiplier from two
// tap streams and accumulates the registered product, with saturation, onto a bias.
module cnn_conv_mac_seq #(
  parameter int A_W   = 9,
  parameter int B_W   = 14,
  parameter int P_W   = 23,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  input  logic [CNT_W-1:0]        len,
  input  logic signed [ACC_W-1:0] bias,
  output logic                    ap_ready,
  output logic                    ap_idle,
  input  logic signed [A_W-1:0]   wgt_dat,
  input  logic                    wgt_vld,
  output logic                    wgt_rdy,
  input  logic signed [B_W-1:0]   pix_dat,
  input  logic                    pix_vld,
  output logic                    pix_rdy,
  output logic signed [A_W-1:0]   mul_a,
  output logic signed [B_W-1:0]   mul_b,
  input  logic signed [P_W-1:0]   mul_p,
  output logic signed [ACC_W-1:0] res_dat,
  output logic                    res_vld,
  input  logic                    res_rdy,
  output logic                    ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        rem;
  logic                    s1;
  logic                    s2;
  logic signed [P_W-1:0]   p_reg;
  logic signed [ACC_W-1:0] acc;

  logic                    taps_left;
  logic                    fire;
  logic signed [ACC_W:0]   sum;
  logic                    clamp;
  logic signed [ACC_W-1:0] acc_nxt;

  // Both streams are handshaken together so a weight never pairs with a stale pixel.
  assign taps_left = (state == RUN) && (rem != '0);
  assign wgt_rdy   = taps_left && pix_vld;
  assign pix_rdy   = taps_left && wgt_vld;
  assign fire      = taps_left && wgt_vld && pix_vld;

  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - P_W){p_reg[P_W-1]}}, p_reg};
    clamp   = sum[ACC_W] != sum[ACC_W-1];
    acc_nxt = sum[ACC_W-1:0];
    if (clamp) begin
      acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      ap_idle  <= 1'b1;
      ap_ready <= 1'b0;
      res_vld  <= 1'b0;
      res_dat  <= '0;
      ovf      <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      rem      <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      p_reg    <= '0;
      acc      <= '0;
    end else begin
      ap_ready <= 1'b0;
      s1       <= fire;
      s2       <= s1;
      p_reg    <= mul_p;
      if (fire) begin
        mul_a <= wgt_dat;
        mul_b <= pix_dat;
        rem   <= rem - 1'b1;
      end
      if (s2) begin
        acc <= acc_nxt;
        if (clamp) ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (ap_start) begin
            ap_ready <= 1'b1;
            ap_idle  <= 1'b0;
            acc      <= bias;
            rem      <= len;
            ovf      <= 1'b0;
            state    <= (len != '0) ? RUN : DRAIN;
          end
        end
        RUN: begin
          if (fire && rem == CNT_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // acc is final once no product is left in flight.
          if (!s1 && !s2) begin
            state   <= OUT;
            res_vld <= 1'b1;
            res_dat <= acc;
          end
        end
        OUT: begin
          if (res_rdy) begin
            state   <= IDLE;
            res_vld <= 1'b0;
            ap_idle <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
